// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES block widths and FP/IP index tables (1-based DES bit numbering)
package des_pkg;

  localparam int DES_BLK_W  = 64;
  localparam int DES_HALF_W = 32;

  // FP_TABLE[i-1] = preoutput bit feeding output bit i
  localparam logic [6:0] FP_TABLE [0:63] = '{
    7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  localparam logic [6:0] IP_TABLE [0:63] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

endpackage

// File: rtl/des_fp_perm.sv
// rtl/des_fp_perm.sv - combinational inverse initial permutation, preoutput to ciphertext
module des_fp_perm
  import des_pkg::*;
(
  input  logic [1:DES_BLK_W] po_i,
  output logic [1:DES_BLK_W] ct_o
);

  for (genvar g = 1; g <= DES_BLK_W; g++) begin : g_bit
    assign ct_o[g] = po_i[FP_TABLE[g-1]];
  end

endmodule

// File: rtl/des_final_permutation_stage.sv
// rtl/des_final_permutation_stage.sv - DES output stage: swap halves, IP^-1, output FIFO, block counter
// Optional FP_SELFCHECK_EN: re-applies IP to each accepted CT and flags mismatches on FP_ERR.
module des_final_permutation_stage
  import des_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [0:DES_HALF_W-1]   L16,
  input  logic [0:DES_HALF_W-1]   R16,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [1:DES_BLK_W]      CT,
  output logic [CNT_W-1:0]        BLK_CNT,
  output logic                    FP_ERR
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [1:DES_BLK_W] po;
  logic [1:DES_BLK_W] ct_perm;

  assign po = {R16, L16};

  des_fp_perm u_fp_perm (
    .po_i (po),
    .ct_o (ct_perm)
  );

  logic [1:DES_BLK_W] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               accept;
  logic               deliver;

  // Ready depends only on registered occupancy, so no OUT_READY -> IN_READY path
  assign IN_READY  = (count_q != FULL_CNT);
  assign OUT_VALID = (count_q != '0);
  assign accept    = IN_VALID && IN_READY;
  assign deliver   = OUT_VALID && OUT_READY;
  assign CT        = OUT_VALID ? mem_q[rd_ptr_q] : '0;
  assign BLK_CNT   = blk_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    blk_cnt_d = blk_cnt_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (deliver) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      blk_cnt_d = blk_cnt_q + CNT_W'(1);
    end
    case ({accept, deliver})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      blk_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  // Storage needs no reset: CT is masked to 0 whenever the FIFO is empty
  always_ff @(posedge CLK) begin
    if (!RST && accept) begin
      mem_q[wr_ptr_q] <= ct_perm;
    end
  end

`ifdef FP_SELFCHECK_EN
  logic [1:DES_BLK_W] ip_chk;
  logic               fp_err_q, fp_err_d;

  for (genvar g = 1; g <= DES_BLK_W; g++) begin : g_ip
    assign ip_chk[g] = ct_perm[IP_TABLE[g-1]];
  end

  always_comb begin
    fp_err_d = fp_err_q;
    if (accept && (ip_chk != po)) begin
      fp_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fp_err_q <= 1'b0;
    end else begin
      fp_err_q <= fp_err_d;
    end
  end

  assign FP_ERR = fp_err_q;
`else
  assign FP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_des_final_permutation_stage.sv
// tb/tb_des_final_permutation_stage.sv - scoreboard bench for des_final_permutation_stage
module tb_des_final_permutation_stage;

  localparam int TB_DEPTH = 2;
  localparam int TB_CNT_W = 8;

  // Standard DES initial permutation; the reference CT is built by inverting it
  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  logic                clk;
  logic                RST;
  logic                IN_VALID;
  logic                IN_READY;
  logic [31:0]         L16;
  logic [31:0]         R16;
  logic                OUT_VALID;
  logic                OUT_READY;
  logic [63:0]         CT;
  logic [TB_CNT_W-1:0] BLK_CNT;
  logic                FP_ERR;

  des_final_permutation_stage #(
    .DEPTH (TB_DEPTH),
    .CNT_W (TB_CNT_W)
  ) dut (
    .CLK       (clk),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .L16       (L16),
    .R16       (R16),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .CT        (CT),
    .BLK_CNT   (BLK_CNT),
    .FP_ERR    (FP_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                  n_tests = 0;
  int                  n_fail  = 0;
  int                  cyc     = 0;
  logic [63:0]         sb [$];
  logic [TB_CNT_W-1:0] model_cnt = '0;
  logic                fp_err_exp = 1'b0;
  logic [63:0]         corrupt_mask = '0;
  bit                  rnd_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_ct(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] po;
    logic [63:0] ct;
    po = {r, l};
    ct = '0;
    for (int j = 1; j <= 64; j++) begin
      ct[6'(64 - IP_T[j-1])] = po[6'(64 - j)];
    end
    return ct;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: occupancy, head value and counter predicted from the scoreboard alone
  always @(negedge clk) begin
    int occ;
    if (RST) begin
      sb.delete();
      model_cnt = '0;
    end else begin
      occ = sb.size();
      check_eq("in_ready", 64'(IN_READY), 64'(occ != TB_DEPTH));
      check_eq("out_valid", 64'(OUT_VALID), 64'(occ != 0));
      check_eq("blk_cnt", 64'(BLK_CNT), 64'(model_cnt));
      check_eq("fp_err", 64'(FP_ERR), 64'(fp_err_exp));
      if (occ != 0) begin
        check_eq("ct_head", CT, sb[0]);
        if (OUT_READY) begin
          void'(sb.pop_front());
          model_cnt = model_cnt + 1'b1;
        end
      end else begin
        check_eq("ct_empty", CT, 64'h0);
      end
      if (IN_VALID && occ != TB_DEPTH) begin
        sb.push_back(model_ct(L16, R16) ^ corrupt_mask);
      end
    end
  end

  // Entered and left just after a rising edge
  task automatic send(input logic [31:0] l, input logic [31:0] r);
    bit done;
    done = 1'b0;
    IN_VALID = 1'b1;
    L16 = l;
    R16 = r;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = IN_READY;
      @(posedge clk);
      #1;
      if (rnd_ready) OUT_READY = 1'($urandom_range(0, 1));
    end
    check_eq("send_accepted", 64'(done), 64'h1);
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    OUT_READY = 1'b1;
    for (int i = 0; i < 32 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 RST = 1'b1;
    @(posedge clk);
    #1 RST = 1'b0;
    fp_err_exp = 1'b0;
  endtask

  initial begin
    logic [31:0] l0, r0;
    int          c0;
    RST = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    L16 = '0;
    R16 = '0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;

    @(negedge clk);
    check_eq("rst_in_ready", 64'(IN_READY), 64'h1);
    check_eq("rst_out_valid", 64'(OUT_VALID), 64'h0);
    check_eq("rst_ct", CT, 64'h0);
    check_eq("rst_blk_cnt", 64'(BLK_CNT), 64'h0);
    @(posedge clk);
    #1;

    // Known vector, one-cycle latency
    OUT_READY = 1'b1;
    send(32'h43423234, 32'h0A4CD995);
    @(negedge clk);
    check_eq("vec1_valid", 64'(OUT_VALID), 64'h1);
    check_eq("vec1_ct", CT, 64'h85E813540F0AB405);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("vec1_cnt", 64'(BLK_CNT), 64'h1);
    @(posedge clk);
    #1;

    send(32'h0, 32'h80000000);
    @(negedge clk);
    check_eq("vec2_ct", CT, 64'h0000000000000040);
    @(posedge clk);
    #1;
    send(32'h0, 32'h0);
    @(negedge clk);
    check_eq("vec0_valid", 64'(OUT_VALID), 64'h1);
    check_eq("vec0_ct", CT, 64'h0);
    @(posedge clk);
    #1;

    // Fill under backpressure, then release
    OUT_READY = 1'b0;
    l0 = $urandom;
    r0 = $urandom;
    send(l0, r0);
    send($urandom, $urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("full_in_ready", 64'(IN_READY), 64'h0);
      check_eq("full_hold_ct", CT, model_ct(l0, r0));
    end
    @(posedge clk);
    #1 OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("after_pop_ready", 64'(IN_READY), 64'h1);
    @(posedge clk);
    #1;
    drain();

    // Reset with blocks queued
    OUT_READY = 1'b0;
    send($urandom, $urandom);
    send($urandom, $urandom);
    pulse_reset();
    @(negedge clk);
    check_eq("mid_rst_valid", 64'(OUT_VALID), 64'h0);
    check_eq("mid_rst_ct", CT, 64'h0);
    check_eq("mid_rst_cnt", 64'(BLK_CNT), 64'h0);
    check_eq("mid_rst_ready", 64'(IN_READY), 64'h1);
    @(posedge clk);
    #1;

    // Streaming: one block per cycle, then random backpressure past the counter wrap
    OUT_READY = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send($urandom, $urandom);
    check_eq("stream_cycles", 64'(cyc - c0), 64'd100);
    drain();
    @(negedge clk);
    check_eq("stream_cnt100", 64'(BLK_CNT), 64'd100);
    @(posedge clk);
    #1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) send($urandom, $urandom);
    rnd_ready = 1'b0;
    drain();
    @(negedge clk);
    check_eq("cnt_wrap", 64'(BLK_CNT), 64'(300 % (1 << TB_CNT_W)));
    @(posedge clk);
    #1;

`ifdef FP_SELFCHECK_EN
    OUT_READY = 1'b0;
    l0 = $urandom;
    r0 = $urandom;
    corrupt_mask = 64'h1;
    force dut.ct_perm = model_ct(l0, r0) ^ 64'h1;
    send(l0, r0);
    release dut.ct_perm;
    corrupt_mask = '0;
    fp_err_exp = 1'b1;
    send($urandom, $urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("fp_err_sticky", 64'(FP_ERR), 64'h1);
    end
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check_eq("fp_err_cleared", 64'(FP_ERR), 64'h0);
    @(posedge clk);
    #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
